// File: rtl/conv_window_mac.sv
// conv_window_mac: 5x5 window x kernel multiply-accumulate with bias, rounding, saturation and optional ReLU.
// One kernel row per cycle; level enable in, finish out, re-armed only by a fresh rising enable.
module conv_window_mac #(
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 11,
    parameter int K         = 5,
    parameter int ACC_W     = 40,
    parameter int RELU_EN   = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable,
    input  logic [K-1:0][K-1:0][DATA_W-1:0]  window_in,
    input  logic [K-1:0][K-1:0][DATA_W-1:0]  kernel_in,
    input  logic [DATA_W-1:0]                bias_in,
    output logic [DATA_W-1:0]                result,
    output logic                             finish,
    output logic                             busy
);
    localparam int RW = (K > 1) ? $clog2(K) : 1;
    localparam logic signed [ACC_W-1:0] MAX_V = (ACC_W'(1) <<< (DATA_W-1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] MIN_V = -MAX_V - ACC_W'(1);
    typedef enum logic [1:0] {IDLE, ACCUM, ROUND, DONE} state_t;
    state_t                            state_q, state_d;
    logic [K-1:0][K-1:0][DATA_W-1:0]   win_q, win_d, ker_q, ker_d;
    logic [DATA_W-1:0]                 bias_q, bias_d, result_q, result_d;
    logic signed [ACC_W-1:0]           acc_q, acc_d;
    logic [RW-1:0]                     row_q, row_d;
    logic                              finish_q, finish_d, armed_q, armed_d;
    logic signed [2*DATA_W-1:0]        prod;
    logic signed [ACC_W-1:0]           row_sum, bias_ext, s, r;
    logic [DATA_W-1:0]                 sat;
    always_comb begin
        prod    = '0;
        row_sum = '0;
        for (int c = 0; c < K; c++) begin
            prod    = $signed(win_q[row_q][c]) * $signed(ker_q[row_q][c]);
            row_sum = row_sum + ACC_W'(prod);
        end
        bias_ext = ACC_W'($signed(bias_q));
        s        = acc_q + (bias_ext <<< FRAC_BITS) + (ACC_W'(1) <<< (FRAC_BITS-1));
        r        = s >>> FRAC_BITS;
        sat      = (r > MAX_V) ? MAX_V[DATA_W-1:0] : (r < MIN_V) ? MIN_V[DATA_W-1:0] : r[DATA_W-1:0];
    end
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        ker_d    = ker_q;
        bias_d   = bias_q;
        acc_d    = acc_q;
        row_d    = row_q;
        result_d = result_q;
        finish_d = finish_q;
        armed_d  = armed_q;
        case (state_q)
            IDLE: begin
                // A start consumes the arming; only enable=0 seen here re-arms.
                if (enable && armed_q) begin
                    win_d    = window_in;
                    ker_d    = kernel_in;
                    bias_d   = bias_in;
                    acc_d    = '0;
                    row_d    = '0;
                    finish_d = 1'b0;
                    armed_d  = 1'b0;
                    state_d  = ACCUM;
                end else if (!enable) begin
                    armed_d = 1'b1;
                end
            end
            ACCUM: begin
                acc_d   = acc_q + row_sum;
                row_d   = row_q + RW'(1);
                state_d = (row_q == RW'(K-1)) ? ROUND : ACCUM;
            end
            ROUND: begin
                result_d = (RELU_EN != 0 && sat[DATA_W-1]) ? '0 : sat;
                finish_d = 1'b1;
                state_d  = DONE;
            end
            default: begin
                finish_d = enable;
                state_d  = enable ? DONE : IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            win_q    <= '0;
            ker_q    <= '0;
            bias_q   <= '0;
            acc_q    <= '0;
            row_q    <= '0;
            result_q <= '0;
            finish_q <= 1'b0;
            armed_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            ker_q    <= ker_d;
            bias_q   <= bias_d;
            acc_q    <= acc_d;
            row_q    <= row_d;
            result_q <= result_d;
            finish_q <= finish_d;
            armed_q  <= armed_d;
        end
    end
    assign result = result_q;
    assign finish = finish_q;
    assign busy   = (state_q == ACCUM) || (state_q == ROUND);
endmodule
